// File: rtl/input_ram_seq.sv
// input_ram_seq: sequencer for the MAP decoder input LLR RAM.
// Loads one frame of signed channel samples into the RAM, then replays it
// forward (alpha sweep) and backward (beta sweep) over a valid/ready port.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   start, frame_len          frame start pulse and length N (1..DEPTH)
//   in_valid/in_ready/in_data channel sample input handshake
//   ram_index/ram_rdwr1/ram_rdwr2/ram_in/ram_out  RAM control and data
//   out_valid/out_ready/out_data/out_dir/out_last sweep output handshake
//   busy, done, len_err       status: active, frame complete, bad length
module input_ram_seq #(
    parameter int unsigned DEPTH = 6144,
    parameter int unsigned AW    = 13,
    parameter int unsigned DW    = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] frame_len,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [AW-1:0] ram_index,
    output logic          ram_rdwr1,
    output logic          ram_rdwr2,
    output logic [DW-1:0] ram_in,
    input  logic [DW-1:0] ram_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_dir,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          len_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FWD  = 3'd2,
        S_BWD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] n_q;
    logic [AW-1:0] wcnt_q;
    logic [AW-1:0] rcnt_q;
    logic [AW-1:0] last_idx;
    logic          len_ok;
    logic          wr_c;
    logic          issue_c;
    logic          accept_c;

    assign last_idx = n_q - AW'(1);
    assign len_ok   = (frame_len != '0) && (frame_len <= AW'(DEPTH));
    assign wr_c     = (state_q == S_LOAD) && in_valid;
    // A read is issued whenever the output slot is empty or being drained.
    assign issue_c  = ((state_q == S_FWD) || (state_q == S_BWD)) &&
                      (!out_valid || out_ready);
    assign accept_c = out_valid && out_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && len_ok) state_d = S_LOAD;
            S_LOAD: if (wr_c && (wcnt_q == last_idx)) state_d = S_FWD;
            S_FWD:  if (issue_c && (rcnt_q == last_idx)) state_d = S_BWD;
            S_BWD:  if (issue_c && (rcnt_q == '0)) state_d = S_DONE;
            S_DONE: if (accept_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RAM strobes and handshake outputs; RAM index is offset by one on reads.
    always_comb begin
        in_ready  = (state_q == S_LOAD);
        busy      = (state_q != S_IDLE);
        ram_rdwr1 = !wr_c;
        ram_rdwr2 = issue_c;
        ram_in    = '0;
        ram_index = '0;
        out_data  = ram_out;
        if (wr_c) begin
            ram_index = wcnt_q;
            ram_in    = in_data;
        end else if (issue_c) begin
            ram_index = rcnt_q + AW'(1);
        end
    end

    // Counters and registered output flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_q       <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_dir   <= 1'b0;
            done      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            n_q    <= frame_len;
                            wcnt_q <= '0;
                            rcnt_q <= '0;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (wr_c) wcnt_q <= wcnt_q + AW'(1);
                end
                S_FWD: begin
                    if (issue_c) begin
                        out_valid <= 1'b1;
                        out_dir   <= 1'b0;
                        out_last  <= (rcnt_q == last_idx);
                        // Hold r at N-1 so the backward sweep restarts there.
                        if (rcnt_q != last_idx) rcnt_q <= rcnt_q + AW'(1);
                    end else if (accept_c) begin
                        out_valid <= 1'b0;
                    end
                end
                S_BWD: begin
                    if (issue_c) begin
                        out_valid <= 1'b1;
                        out_dir   <= 1'b1;
                        out_last  <= (rcnt_q == '0);
                        if (rcnt_q != '0) rcnt_q <= rcnt_q - AW'(1);
                    end else if (accept_c) begin
                        out_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (accept_c) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_dir   <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_input_ram_seq.sv
module tb_input_ram_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] frame_len;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;
    logic [12:0] ram_index;
    logic        ram_rdwr1;
    logic        ram_rdwr2;
    logic [11:0] ram_in;
    logic [11:0] ram_out = '0;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_dir;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        len_err;

    input_ram_seq dut (
        .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_index(ram_index), .ram_rdwr1(ram_rdwr1), .ram_rdwr2(ram_rdwr2),
        .ram_in(ram_in), .ram_out(ram_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_dir(out_dir),
        .out_last(out_last), .busy(busy), .done(done), .len_err(len_err)
    );

    initial forever #5 clock = ~clock;

    typedef struct packed {
        logic [11:0] d;
        logic        dir;
        logic        last;
    } rec_t;

    typedef struct {
        int unsigned n;
        int          kind;    // 0 fixed, 1 ramp, 2 random
        bit          rnd;     // random in_valid gaps and out_ready
        bit          exp_err; // expected len_err pulse instead of a frame
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [11:0] mem  [0:6143];
    logic [11:0] samp [0:6143];
    rec_t        q[$];
    int          wexp, rd_cnt, max_rd, done_cnt, done_cyc, acc_cyc;
    bit          rnd_rdy = 0;
    bit          prev_ok = 0;
    logic        prev_v, prev_rdy, prev_dir, prev_last;
    logic [11:0] prev_d;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // RAM model following the one-cycle registered read contract.
    always @(posedge clock) begin
        cyc++;
        if (!ram_rdwr1 && ram_index < 13'd6144) mem[ram_index] <= ram_in;
        if (ram_rdwr2 && ram_index != 0 && ram_index <= 13'd6144)
            ram_out <= mem[ram_index - 13'd1];
    end

    // Output-ready driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Protocol monitor: write order/data, strobe legality, stall stability.
    always @(negedge clock) begin
        if (reset) begin
            prev_ok = 0;
        end else begin
            if (!ram_rdwr1 && ram_rdwr2) chk("both strobes", 1, 0);
            if (ram_rdwr2 && ram_index == 0) chk("read at index 0", 1, 0);
            if (!ram_rdwr1) begin
                chk("write index", ram_index, wexp);
                chk("write data", ram_in, samp[wexp]);
                wexp++;
            end
            if (ram_rdwr2) begin
                rd_cnt++;
                if (int'(ram_index) > max_rd) max_rd = int'(ram_index);
            end
            if (prev_ok && prev_v && !prev_rdy) begin
                chk("stall valid", out_valid, 1);
                chk("stall data", out_data, prev_d);
                chk("stall dir", out_dir, prev_dir);
                chk("stall last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                q.push_back('{d: out_data, dir: out_dir, last: out_last});
                acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_ok = 1; prev_v = out_valid; prev_rdy = out_ready;
            prev_d = out_data; prev_dir = out_dir; prev_last = out_last;
        end
    end

    task automatic fill(input int n, input int kind);
        logic [11:0] fixed4 [0:3];
        fixed4[0] = 12'd10; fixed4[1] = -12'sd20; fixed4[2] = 12'd30; fixed4[3] = 12'h800;
        for (int i = 0; i < n && i < 6144; i++) begin
            case (kind)
                0:       samp[i] = fixed4[i % 4];
                1:       samp[i] = 12'(i % 2048);
                default: samp[i] = 12'($urandom);
            endcase
        end
    endtask

    task automatic start_frame(input int n);
        q.delete();
        wexp = 0; rd_cnt = 0; max_rd = 0; done_cnt = 0; done_cyc = 0; acc_cyc = 0;
        start = 1'b1;
        frame_len = 13'(n);
        step();
        start = 1'b0;
    endtask

    task automatic load(input int n, input bit rnd);
        int i = 0;
        int b = 0;
        while (i < n && b < 20 * n + 100) begin
            in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = samp[i];
            @(negedge clock);
            if (in_valid) begin
                chk("in_ready during load", in_ready, 1);
                if (in_ready) i++;
            end
            b++;
            step();
        end
        in_valid = 1'b0;
        chk("samples loaded", i, n);
        @(negedge clock);
        chk("in_ready after load", in_ready, 0);
    endtask

    task automatic wait_done(input int n);
        int b = 0;
        rec_t e;
        while (done_cnt == 0 && b < 8 * n + 200) begin
            @(negedge clock);
            b++;
        end
        chk("done seen", done_cnt != 0, 1);
        step(); step();
        @(negedge clock);
        chk("done pulses", done_cnt, 1);
        chk("done latency", done_cyc - acc_cyc, 1);
        chk("busy after done", busy, 0);
        chk("writes", wexp, n);
        chk("read issues", rd_cnt, 2 * n);
        chk("max read index", max_rd, n);
        chk("output count", q.size(), 2 * n);
        for (int k = 0; k < q.size() && k < 2 * n; k++) begin
            if (k < n) e = '{d: samp[k], dir: 1'b0, last: (k == n - 1)};
            else       e = '{d: samp[2*n-1-k], dir: 1'b1, last: (k == 2*n - 1)};
            chk("out data", q[k].d, e.d);
            chk("out dir", q[k].dir, e.dir);
            chk("out last", q[k].last, e.last);
        end
    endtask

    task automatic chk_reset_vals();
        @(negedge clock);
        chk("rst in_ready", in_ready, 0);
        chk("rst ram_rdwr1", ram_rdwr1, 1);
        chk("rst ram_rdwr2", ram_rdwr2, 0);
        chk("rst ram_index", ram_index, 0);
        chk("rst ram_in", ram_in, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst out_dir", out_dir, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst len_err", len_err, 0);
    endtask

    vec_t tbl [0:5];

    initial begin
        tbl[0] = '{n: 4,    kind: 0, rnd: 0, exp_err: 0};
        tbl[1] = '{n: 0,    kind: 0, rnd: 0, exp_err: 1};
        tbl[2] = '{n: 6145, kind: 0, rnd: 0, exp_err: 1};
        tbl[3] = '{n: 6144, kind: 1, rnd: 0, exp_err: 0};
        tbl[4] = '{n: 37,   kind: 2, rnd: 1, exp_err: 0};
        tbl[5] = '{n: 1,    kind: 2, rnd: 0, exp_err: 0};

        reset = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;
        wexp = 0; rd_cnt = 0; max_rd = 0; done_cnt = 0;
        step(); step();
        chk_reset_vals();
        step();
        reset = 1'b0;
        step();

        for (int t = 0; t < 6; t++) begin
            rnd_rdy = tbl[t].rnd;
            fill(int'(tbl[t].n), tbl[t].kind);
            start_frame(int'(tbl[t].n));
            @(negedge clock);
            if (tbl[t].exp_err) begin
                chk("len_err pulse", len_err, 1);
                chk("busy on bad len", busy, 0);
                step();
                @(negedge clock);
                chk("len_err clears", len_err, 0);
                chk("no strobes on bad len", wexp + rd_cnt, 0);
                step();
            end else begin
                chk("busy after start", busy, 1);
                step();
                load(int'(tbl[t].n), tbl[t].rnd);
                wait_done(int'(tbl[t].n));
                step();
            end
            rnd_rdy = 0;
        end

        // Reset in the middle of the backward sweep, then a fresh short frame.
        begin
            int b = 0;
            fill(8, 2);
            start_frame(8);
            load(8, 0);
            while (!(out_valid && out_dir) && b < 100) begin
                @(negedge clock);
                b++;
            end
            chk("reached bwd", out_valid && out_dir, 1);
            step();
            reset = 1'b1;
            step();
            chk_reset_vals();
            step();
            reset = 1'b0;
            step();
            fill(3, 2);
            start_frame(3);
            load(3, 0);
            wait_done(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
